dreimann_round_ctrl: RTL and testbench

Round sequencer for the DreiMann dice game. It waits until both dice controllers have latched a value, then evaluates the game rule. It time-shares the seven-segment display path between die 1, die 2 and the round result, and re-arms both dice controllers once the player acknowledges. It sits between the two dice controllers and the display logic / seven-segment decoder.

---
 rtl/dreimann_round_ctrl_pkg.sv | 39 +++
 rtl/dreimann_round_ctrl_if.sv | 28 ++
 rtl/dreimann_round_ctrl_show_timer.sv | 27 ++
 rtl/dreimann_round_ctrl.sv | 174 +++++++++++++++++
 tb/tb_dreimann_round_ctrl.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/dreimann_round_ctrl_pkg.sv
// Shared definitions for the DreiMann round sequencer: state encodings, result codes,
// display-source codes and the game-rule evaluation function.
package dreimann_round_ctrl_pkg;

  typedef enum logic [2:0] {
    StWait    = 3'd0,
    StEval    = 3'd1,
    StShowD1  = 3'd2,
    StShowD2  = 3'd3,
    StShowRes = 3'd4,
    StClear   = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    ResNone  = 2'd0,
    ResDrink = 2'd1,
    ResNewDm = 2'd2,
    ResDouble = 2'd3
  } result_e;

  typedef enum logic [1:0] {
    SelBlank = 2'd0,
    SelD1    = 2'd1,
    SelD2    = 2'd2,
    SelRes   = 2'd3
  } sel_e;

  // Game rule; the order of the checks encodes the rule priority (3+3 is DRINK, not DOUBLE).
  function automatic result_e eval_result(input logic [2:0] v1, input logic [2:0] v2);
    logic [3:0] sum;
    sum = {1'b0, v1} + {1'b0, v2};
    if (v1 == 3'd0 || v1 == 3'd7 || v2 == 3'd0 || v2 == 3'd7) return ResNone;
    else if (sum == 4'd3)                                      return ResNewDm;
    else if (v1 == 3'd3 || v2 == 3'd3)                         return ResDrink;
    else if (v1 == v2)                                         return ResDouble;
    else                                                       return ResNone;
  endfunction

endpackage

// File: rtl/dreimann_round_ctrl_if.sv
// Handshake/display bundle between the dice controllers, the round sequencer and the
// display path.
//   master: drives done1/val1/done2/val2/ack, observes sequencer outputs.
//   slave : the round sequencer itself.
interface dreimann_round_ctrl_if;
  logic       done1;
  logic [2:0] val1;
  logic       done2;
  logic [2:0] val2;
  logic       ack;
  logic       rearm;
  logic [1:0] disp_sel;
  logic [3:0] disp_val;
  logic [1:0] result;
  logic       result_valid;
  logic [3:0] drink_count;
  logic       busy;

  modport master (
    output done1, val1, done2, val2, ack,
    input  rearm, disp_sel, disp_val, result, result_valid, drink_count, busy
  );

  modport slave (
    input  done1, val1, done2, val2, ack,
    output rearm, disp_sel, disp_val, result, result_valid, drink_count, busy
  );
endinterface

// File: rtl/dreimann_round_ctrl_show_timer.sv
// 24-bit loadable down-counter. done_o is high while the count is zero; load_i takes
// priority over counting.
//   clk_i, rst_i (async, active-high), load_i, load_val_i[23:0], done_o
module dreimann_round_ctrl_show_timer (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic [23:0] load_val_i,
  output logic        done_o
);

  logic [23:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)              cnt_d = load_val_i;
    else if (cnt_q != 24'd0) cnt_d = cnt_q - 24'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= 24'd0;
    else       cnt_q <= cnt_d;
  end

  assign done_o = (cnt_q == 24'd0);

endmodule

// File: rtl/dreimann_round_ctrl.sv
// DreiMann round sequencer. Latches both dice, evaluates the rule, shows die 1, die 2
// and the result on the shared display path, then re-arms the dice on ack.
//   clk, rst (async, active-high)
//   bus (slave): done1/val1, done2/val2, ack in; rearm, disp_sel, disp_val, result,
//                result_valid, drink_count, busy out
// Optional: define DREIMANN_AUTO_ADVANCE_EN to leave SHOW_RES after 4*SHOW_CYCLES
// cycles without ack.
module dreimann_round_ctrl
  import dreimann_round_ctrl_pkg::*;
#(
  parameter int unsigned SHOW_CYCLES = 5_000_000
) (
  input logic                 clk,
  input logic                 rst,
  dreimann_round_ctrl_if.slave bus
);

  localparam logic [23:0] ShowLoad = 24'(SHOW_CYCLES - 1);

  state_e     state_q, state_d;
  logic       lat1_q, lat1_d, lat2_q, lat2_d;
  logic [2:0] val1_q, val1_d, val2_q, val2_d;
  result_e    result_q, result_d;
  logic       result_valid_q, result_valid_d;
  logic [1:0] disp_sel_q, disp_sel_d;
  logic [3:0] disp_val_q, disp_val_d;
  logic [3:0] drink_q, drink_d;
  logic       tmr_load, tmr_done;
`ifdef DREIMANN_AUTO_ADVANCE_EN
  // SHOW_RES timeout runs the shared timer for four laps of SHOW_CYCLES.
  logic [1:0] lap_q, lap_d;
`endif

  dreimann_round_ctrl_show_timer u_show_timer (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_i     (tmr_load),
    .load_val_i (ShowLoad),
    .done_o     (tmr_done)
  );

  always_comb begin
    state_d  = state_q;
    lat1_d   = lat1_q;
    lat2_d   = lat2_q;
    val1_d   = val1_q;
    val2_d   = val2_q;
    result_d = result_q;
    drink_d  = drink_q;
    tmr_load = 1'b0;
`ifdef DREIMANN_AUTO_ADVANCE_EN
    lap_d    = lap_q;
`endif
    unique case (state_q)
      StWait: begin
        if (bus.done1 && !lat1_q) begin
          lat1_d = 1'b1;
          val1_d = bus.val1;
        end
        if (bus.done2 && !lat2_q) begin
          lat2_d = 1'b1;
          val2_d = bus.val2;
        end
        if (lat1_d && lat2_d) state_d = StEval;
      end
      StEval: begin
        result_d = eval_result(val1_q, val2_q);
        if (result_d == ResDrink && drink_q != 4'hf) drink_d = drink_q + 4'd1;
        tmr_load = 1'b1;
        state_d  = StShowD1;
      end
      StShowD1: begin
        if (tmr_done) begin
          tmr_load = 1'b1;
          state_d  = StShowD2;
        end
      end
      StShowD2: begin
        if (tmr_done) begin
          tmr_load = 1'b1;
          state_d  = StShowRes;
`ifdef DREIMANN_AUTO_ADVANCE_EN
          lap_d    = 2'd0;
`endif
        end
      end
      StShowRes: begin
        if (bus.ack) begin
          state_d = StClear;
        end
`ifdef DREIMANN_AUTO_ADVANCE_EN
        else if (tmr_done) begin
          if (lap_q == 2'd3) begin
            state_d = StClear;
          end else begin
            lap_d    = lap_q + 2'd1;
            tmr_load = 1'b1;
          end
        end
`endif
      end
      StClear: begin
        lat1_d  = 1'b0;
        lat2_d  = 1'b0;
        state_d = StWait;
      end
      default: state_d = StWait;
    endcase
  end

  // Display outputs are registered from the next state so they are valid in the first
  // cycle of each SHOW state.
  always_comb begin
    disp_sel_d     = SelBlank;
    disp_val_d     = 4'd0;
    result_valid_d = (state_d == StShowRes);
    unique case (state_d)
      StShowD1: begin
        disp_sel_d = SelD1;
        disp_val_d = {1'b0, val1_q};
      end
      StShowD2: begin
        disp_sel_d = SelD2;
        disp_val_d = {1'b0, val2_q};
      end
      StShowRes: begin
        disp_sel_d = SelRes;
        disp_val_d = {2'b00, result_q};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StWait;
      lat1_q         <= 1'b0;
      lat2_q         <= 1'b0;
      val1_q         <= 3'd0;
      val2_q         <= 3'd0;
      result_q       <= ResNone;
      result_valid_q <= 1'b0;
      disp_sel_q     <= 2'd0;
      disp_val_q     <= 4'd0;
      drink_q        <= 4'd0;
`ifdef DREIMANN_AUTO_ADVANCE_EN
      lap_q          <= 2'd0;
`endif
    end else begin
      state_q        <= state_d;
      lat1_q         <= lat1_d;
      lat2_q         <= lat2_d;
      val1_q         <= val1_d;
      val2_q         <= val2_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      disp_sel_q     <= disp_sel_d;
      disp_val_q     <= disp_val_d;
      drink_q        <= drink_d;
`ifdef DREIMANN_AUTO_ADVANCE_EN
      lap_q          <= lap_d;
`endif
    end
  end

  assign bus.rearm        = (state_q == StClear);
  assign bus.busy         = (state_q != StWait);
  assign bus.disp_sel     = disp_sel_q;
  assign bus.disp_val     = disp_val_q;
  assign bus.result       = result_q;
  assign bus.result_valid = result_valid_q;
  assign bus.drink_count  = drink_q;

endmodule

// File: tb/tb_dreimann_round_ctrl.sv
// Directed bench for dreimann_round_ctrl: table of complete rounds plus hand-written
// sequences for repeat/ignored done pulses, saturation, mid-round reset and SHOW_RES exit.
module tb_dreimann_round_ctrl;

  localparam int unsigned S = 2;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  int   drink_exp;

  dreimann_round_ctrl_if bus ();

  dreimann_round_ctrl #(.SHOW_CYCLES(S)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] v1;
    logic [2:0] v2;
    bit         simul;
    int         exp_res;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulses(input logic [2:0] v1, input logic [2:0] v2, input bit simul);
    if (simul) begin
      bus.done1 = 1'b1; bus.val1 = v1;
      bus.done2 = 1'b1; bus.val2 = v2;
      cyc();
      bus.done1 = 1'b0; bus.done2 = 1'b0;
    end else begin
      bus.done1 = 1'b1; bus.val1 = v1;
      cyc();
      bus.done1 = 1'b0;
      chk("wait_one_latched_busy", int'(bus.busy), 0);
      bus.done2 = 1'b1; bus.val2 = v2;
      cyc();
      bus.done2 = 1'b0;
    end
  endtask

  // Entered in the EVAL cycle; returns in the first SHOW_RES cycle. poke drives done
  // pulses with other values during SHOW_D1, which must not change anything.
  task automatic eval_and_show(input logic [2:0] v1, input logic [2:0] v2, input int exp_res,
                               input bit poke);
    chk("eval_busy", int'(bus.busy), 1);
    chk("eval_disp_sel", int'(bus.disp_sel), 0);
    chk("eval_result_valid", int'(bus.result_valid), 0);
    if (exp_res == 1 && drink_exp < 15) drink_exp++;
    cyc();
    chk("d1_result", int'(bus.result), exp_res);
    chk("d1_drink_count", int'(bus.drink_count), drink_exp);
    chk("d1_disp_val", int'(bus.disp_val), int'(v1));
    for (int i = 0; i < int'(S); i++) begin
      chk("d1_disp_sel", int'(bus.disp_sel), 1);
      if (poke && i == 0) begin
        bus.done1 = 1'b1; bus.val1 = 3'd5;
        bus.done2 = 1'b1; bus.val2 = 3'd1;
      end else begin
        bus.done1 = 1'b0; bus.done2 = 1'b0;
      end
      cyc();
    end
    bus.done1 = 1'b0; bus.done2 = 1'b0;
    chk("d2_disp_val", int'(bus.disp_val), int'(v2));
    for (int i = 0; i < int'(S); i++) begin
      chk("d2_disp_sel", int'(bus.disp_sel), 2);
      chk("d2_result_valid", int'(bus.result_valid), 0);
      cyc();
    end
    chk("res_disp_sel", int'(bus.disp_sel), 3);
    chk("res_disp_val", int'(bus.disp_val), exp_res);
    chk("res_result_valid", int'(bus.result_valid), 1);
    chk("res_rearm", int'(bus.rearm), 0);
  endtask

  task automatic ack_round();
    bus.ack = 1'b1;
    cyc();
    bus.ack = 1'b0;
    chk("clear_rearm", int'(bus.rearm), 1);
    chk("clear_result_valid", int'(bus.result_valid), 0);
    chk("clear_disp_sel", int'(bus.disp_sel), 0);
    cyc();
    chk("wait_rearm", int'(bus.rearm), 0);
    chk("wait_busy", int'(bus.busy), 0);
  endtask

  task automatic run_round(input logic [2:0] v1, input logic [2:0] v2, input bit simul,
                           input int exp_res);
    chk("start_busy", int'(bus.busy), 0);
    pulses(v1, v2, simul);
    eval_and_show(v1, v2, exp_res, 1'b0);
    ack_round();
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    drink_exp = 0;
    vecs[0] = '{v1: 3'd1, v2: 3'd2, simul: 1'b0, exp_res: 2};
    vecs[1] = '{v1: 3'd3, v2: 3'd3, simul: 1'b1, exp_res: 1};
    vecs[2] = '{v1: 3'd4, v2: 3'd4, simul: 1'b1, exp_res: 3};
    vecs[3] = '{v1: 3'd0, v2: 3'd5, simul: 1'b0, exp_res: 0};
    vecs[4] = '{v1: 3'd7, v2: 3'd3, simul: 1'b1, exp_res: 0};
    vecs[5] = '{v1: 3'd2, v2: 3'd1, simul: 1'b0, exp_res: 2};
    vecs[6] = '{v1: 3'd3, v2: 3'd5, simul: 1'b0, exp_res: 1};
    vecs[7] = '{v1: 3'd6, v2: 3'd6, simul: 1'b1, exp_res: 3};
    vecs[8] = '{v1: 3'd2, v2: 3'd5, simul: 1'b0, exp_res: 0};
    vecs[9] = '{v1: 3'd3, v2: 3'd0, simul: 1'b1, exp_res: 0};

    rst = 1'b1;
    bus.done1 = 1'b0; bus.val1 = 3'd0;
    bus.done2 = 1'b0; bus.val2 = 3'd0;
    bus.ack = 1'b0;
    cyc();
    cyc();
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_rearm", int'(bus.rearm), 0);
    chk("reset_disp_sel", int'(bus.disp_sel), 0);
    chk("reset_result", int'(bus.result), 0);
    chk("reset_drink", int'(bus.drink_count), 0);
    rst = 1'b0;
    cyc();

    // Table of complete rounds.
    for (int k = 0; k < 10; k++) begin
      run_round(vecs[k].v1, vecs[k].v2, vecs[k].simul, vecs[k].exp_res);
    end

    // Repeat done1 keeps the first value; dones during SHOW and CLEAR are ignored.
    bus.done1 = 1'b1; bus.val1 = 3'd4;
    cyc();
    bus.val1 = 3'd6;
    cyc();
    bus.done1 = 1'b0;
    chk("repeat_still_wait", int'(bus.busy), 0);
    bus.done2 = 1'b1; bus.val2 = 3'd4;
    cyc();
    bus.done2 = 1'b0;
    eval_and_show(3'd4, 3'd4, 3, 1'b1);
    bus.ack = 1'b1;
    cyc();
    bus.ack = 1'b0;
    chk("clear_rearm_seq", int'(bus.rearm), 1);
    bus.done1 = 1'b1; bus.val1 = 3'd3;
    cyc();
    bus.done1 = 1'b0;
    chk("after_clear_busy", int'(bus.busy), 0);
    bus.done2 = 1'b1; bus.val2 = 3'd3;
    cyc();
    bus.done2 = 1'b0;
    chk("clear_done_ignored", int'(bus.busy), 0);
    bus.done1 = 1'b1; bus.val1 = 3'd2;
    cyc();
    bus.done1 = 1'b0;
    eval_and_show(3'd2, 3'd3, 1, 1'b0);
    ack_round();

    // Saturation of drink_count, then an out-of-range die.
    for (int k = 0; k < 16; k++) run_round(3'd3, 3'd1, 1'b0, 1);
    chk("drink_saturated", int'(bus.drink_count), 15);
    run_round(3'd0, 3'd5, 1'b0, 0);

    // Reset during SHOW_D2: asynchronous clear, no rearm.
    pulses(3'd3, 3'd3, 1'b1);
    cyc();
    for (int i = 0; i < int'(S); i++) cyc();
    chk("pre_reset_d2_sel", int'(bus.disp_sel), 2);
    rst = 1'b1;
    #1;
    chk("async_busy", int'(bus.busy), 0);
    chk("async_disp_sel", int'(bus.disp_sel), 0);
    chk("async_disp_val", int'(bus.disp_val), 0);
    chk("async_result", int'(bus.result), 0);
    chk("async_drink", int'(bus.drink_count), 0);
    chk("async_rearm", int'(bus.rearm), 0);
    cyc();
    chk("reset_hold_rearm", int'(bus.rearm), 0);
    rst = 1'b0;
    drink_exp = 0;
    cyc();
    chk("post_reset_rearm", int'(bus.rearm), 0);
    run_round(3'd5, 3'd5, 1'b0, 3);
    run_round(3'd3, 3'd6, 1'b1, 1);

    // SHOW_RES without ack.
    pulses(3'd2, 3'd2, 1'b1);
    eval_and_show(3'd2, 3'd2, 3, 1'b0);
`ifdef DREIMANN_AUTO_ADVANCE_EN
    for (int i = 0; i < 4 * int'(S); i++) begin
      chk("auto_hold_valid", int'(bus.result_valid), 1);
      chk("auto_hold_rearm", int'(bus.rearm), 0);
      cyc();
    end
    chk("auto_clear_rearm", int'(bus.rearm), 1);
    cyc();
    chk("auto_wait_busy", int'(bus.busy), 0);
`else
    for (int i = 0; i < 10 * int'(S); i++) begin
      chk("noack_hold_valid", int'(bus.result_valid), 1);
      chk("noack_hold_rearm", int'(bus.rearm), 0);
      cyc();
    end
    ack_round();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
